// File: rtl/calcore_pkg.sv
// Shared definitions for the CalCore instruction issuer: opcodes, field widths
// and the issuer state encoding.
package calcore_pkg;

    localparam int REG_W = 5;
    localparam int IMM_W = 12;
    localparam int F7_W  = 7;

    localparam logic [6:0] OP_SET_HEIGHT = 7'b0001011;
    localparam logic [6:0] OP_SET_WEIGHT = 7'b0001100;
    localparam logic [6:0] OP_CALC_BMI   = 7'b0001101;
    localparam logic [6:0] OP_CALC_BMR   = 7'b0001110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT_H,
        ST_EMIT_W,
        ST_EMIT_BMI,
        ST_EMIT_BMR,
        ST_GAP
    } issuer_state_t;

    // True for the states that present a word on the instruction port.
    function automatic logic is_emit_state(input issuer_state_t s);
        return (s == ST_EMIT_H) || (s == ST_EMIT_W) ||
               (s == ST_EMIT_BMI) || (s == ST_EMIT_BMR);
    endfunction

endpackage

// File: rtl/calcore_instr_encode.sv
// Combinational CalCore instruction encoder. The SET_* opcodes use the I-type
// layout (12-bit immediate in [31:20]); everything else uses the R-type layout.
module calcore_instr_encode
    import calcore_pkg::*;
(
    input  logic [6:0]       op,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [IMM_W-1:0] imm,
    input  logic [F7_W-1:0]  funct7,
    output logic [31:0]      word
);

    // Pack the fields according to the instruction format implied by the opcode.
    always_comb begin
        word = '0;
        if ((op == OP_SET_HEIGHT) || (op == OP_SET_WEIGHT)) begin
            word = {imm, rs1, 3'b000, rd, op};
        end else begin
            word = {funct7, rs2, rs1, 3'b000, rd, op};
        end
    end

endmodule

// File: rtl/calcore_instr_issuer.sv
// CalCore instruction issuer: accepts one profile request and issues the
// SET_HEIGHT / SET_WEIGHT / CALC_BMI / CALC_BMR sequence over a valid/ready port.
// Optional build macro CALCORE_SKIP_UNCHANGED_EN: skip SET_HEIGHT / SET_WEIGHT
// when the same value was last issued to the same register.
module calcore_instr_issuer
    import calcore_pkg::*;
#(
    parameter int EMIT_BMR = 1,
    parameter int IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IMM_W-1:0] req_height,
    input  logic [IMM_W-1:0] req_weight,
    input  logic [F7_W-1:0]  req_funct7,
    input  logic [REG_W-1:0] req_rd_h,
    input  logic [REG_W-1:0] req_rd_w,
    input  logic [REG_W-1:0] req_rd_bmi,
    input  logic [REG_W-1:0] req_rd_bmr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             busy,
    output logic             seq_done
);

    localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

    issuer_state_t    state;
    issuer_state_t    state_next;
    issuer_state_t    pend_state;
    issuer_state_t    follow;
    logic             advance;
    logic             last_hs;
    logic             accept;
    logic             load_word;
    logic [3:0]       gap_cnt;
    logic [31:0]      instr_reg;
    logic             seq_done_reg;

    logic [IMM_W-1:0] lat_height;
    logic [IMM_W-1:0] lat_weight;
    logic [F7_W-1:0]  lat_funct7;
    logic [REG_W-1:0] lat_rd_h;
    logic [REG_W-1:0] lat_rd_w;
    logic [REG_W-1:0] lat_rd_bmi;
    logic [REG_W-1:0] lat_rd_bmr;

    logic [IMM_W-1:0] src_height;
    logic [IMM_W-1:0] src_weight;
    logic [F7_W-1:0]  src_funct7;
    logic [REG_W-1:0] src_rd_h;
    logic [REG_W-1:0] src_rd_w;
    logic [REG_W-1:0] src_rd_bmi;
    logic [REG_W-1:0] src_rd_bmr;

    logic             skip_h;
    logic             skip_w;

    logic [6:0]       enc_op;
    logic [REG_W-1:0] enc_rd;
    logic [REG_W-1:0] enc_rs1;
    logic [REG_W-1:0] enc_rs2;
    logic [IMM_W-1:0] enc_imm;
    logic [F7_W-1:0]  enc_f7;
    logic [31:0]      enc_word;

    assign req_ready   = (state == ST_IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign instr_valid = is_emit_state(state);
    assign instr       = instr_reg;
    assign busy        = (state != ST_IDLE);
    assign seq_done    = seq_done_reg;

    // While idle the first word is built straight from the request port, since
    // the latched copy only becomes valid on the acceptance edge.
    always_comb begin
        src_height = lat_height;
        src_weight = lat_weight;
        src_funct7 = lat_funct7;
        src_rd_h   = lat_rd_h;
        src_rd_w   = lat_rd_w;
        src_rd_bmi = lat_rd_bmi;
        src_rd_bmr = lat_rd_bmr;
        if (state == ST_IDLE) begin
            src_height = req_height;
            src_weight = req_weight;
            src_funct7 = req_funct7;
            src_rd_h   = req_rd_h;
            src_rd_w   = req_rd_w;
            src_rd_bmi = req_rd_bmi;
            src_rd_bmr = req_rd_bmr;
        end
    end

`ifdef CALCORE_SKIP_UNCHANGED_EN
    logic             h_cache_valid;
    logic [IMM_W-1:0] h_cache_height;
    logic [REG_W-1:0] h_cache_rd;
    logic             w_cache_valid;
    logic [IMM_W-1:0] w_cache_weight;
    logic [REG_W-1:0] w_cache_rd;

    // Remember the last height/weight actually handed to the core, per register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cache_valid  <= 1'b0;
            h_cache_height <= '0;
            h_cache_rd     <= '0;
            w_cache_valid  <= 1'b0;
            w_cache_weight <= '0;
            w_cache_rd     <= '0;
        end else begin
            if ((state == ST_EMIT_H) && instr_ready) begin
                h_cache_valid  <= 1'b1;
                h_cache_height <= lat_height;
                h_cache_rd     <= lat_rd_h;
            end
            if ((state == ST_EMIT_W) && instr_ready) begin
                w_cache_valid  <= 1'b1;
                w_cache_weight <= lat_weight;
                w_cache_rd     <= lat_rd_w;
            end
        end
    end

    assign skip_h = h_cache_valid && (h_cache_height == src_height) && (h_cache_rd == src_rd_h);
    assign skip_w = w_cache_valid && (w_cache_weight == src_weight) && (w_cache_rd == src_rd_w);
`else
    assign skip_h = 1'b0;
    assign skip_w = 1'b0;
`endif

    // Next-state logic: walk the emit states on each handshake, detour through
    // GAP when an idle gap is configured, and return to IDLE after the last word.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        follow     = ST_IDLE;
        last_hs    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!skip_h) begin
                        state_next = ST_EMIT_H;
                    end else if (!skip_w) begin
                        state_next = ST_EMIT_W;
                    end else begin
                        state_next = ST_EMIT_BMI;
                    end
                end
            end
            ST_EMIT_H: begin
                if (instr_ready) begin
                    advance = 1'b1;
                    follow  = skip_w ? ST_EMIT_BMI : ST_EMIT_W;
                end
            end
            ST_EMIT_W: begin
                if (instr_ready) begin
                    advance = 1'b1;
                    follow  = ST_EMIT_BMI;
                end
            end
            ST_EMIT_BMI: begin
                if (instr_ready) begin
                    if (EMIT_BMR != 0) begin
                        advance = 1'b1;
                        follow  = ST_EMIT_BMR;
                    end else begin
                        last_hs = 1'b1;
                    end
                end
            end
            ST_EMIT_BMR: begin
                if (instr_ready) begin
                    last_hs = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = pend_state;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (advance) begin
            state_next = (IDLE_GAP > 0) ? ST_GAP : follow;
        end
        if (last_hs) begin
            state_next = ST_IDLE;
        end
    end

    // Select the fields of the word belonging to the state being entered.
    always_comb begin
        enc_op  = '0;
        enc_rd  = '0;
        enc_rs1 = '0;
        enc_rs2 = '0;
        enc_imm = '0;
        enc_f7  = '0;
        case (state_next)
            ST_EMIT_H: begin
                enc_op  = OP_SET_HEIGHT;
                enc_rd  = src_rd_h;
                enc_imm = src_height;
            end
            ST_EMIT_W: begin
                enc_op  = OP_SET_WEIGHT;
                enc_rd  = src_rd_w;
                enc_imm = src_weight;
            end
            ST_EMIT_BMI: begin
                enc_op  = OP_CALC_BMI;
                enc_rd  = src_rd_bmi;
                enc_rs1 = src_rd_h;
                enc_rs2 = src_rd_w;
            end
            ST_EMIT_BMR: begin
                enc_op  = OP_CALC_BMR;
                enc_rd  = src_rd_bmr;
                enc_rs1 = src_rd_h;
                enc_rs2 = src_rd_w;
                enc_f7  = src_funct7;
            end
            default: enc_op = '0;
        endcase
    end

    assign load_word = (state_next != state) && is_emit_state(state_next);

    calcore_instr_encode u_encode (
        .op     (enc_op),
        .rd     (enc_rd),
        .rs1    (enc_rs1),
        .rs2    (enc_rs2),
        .imm    (enc_imm),
        .funct7 (enc_f7),
        .word   (enc_word)
    );

    // State register, gap counter and the output word register; the word is
    // loaded only on entry to an emit state so it stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pend_state   <= ST_IDLE;
            gap_cnt      <= '0;
            instr_reg    <= '0;
            seq_done_reg <= 1'b0;
        end else begin
            state        <= state_next;
            seq_done_reg <= last_hs;
            if (advance) begin
                pend_state <= follow;
            end
            if ((state == ST_GAP) && (state_next == ST_GAP)) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
            if (load_word) begin
                instr_reg <= enc_word;
            end
        end
    end

    // Capture the request on acceptance; later port changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_height <= '0;
            lat_weight <= '0;
            lat_funct7 <= '0;
            lat_rd_h   <= '0;
            lat_rd_w   <= '0;
            lat_rd_bmi <= '0;
            lat_rd_bmr <= '0;
        end else if (accept) begin
            lat_height <= req_height;
            lat_weight <= req_weight;
            lat_funct7 <= req_funct7;
            lat_rd_h   <= req_rd_h;
            lat_rd_w   <= req_rd_w;
            lat_rd_bmi <= req_rd_bmi;
            lat_rd_bmr <= req_rd_bmr;
        end
    end

endmodule

// File: tb/tb_calcore_instr_issuer.sv
// Self-checking bench for calcore_instr_issuer: a per-cycle vector table for
// the default configuration plus hand-written back-to-back, idle-gap and
// (with CALCORE_SKIP_UNCHANGED_EN) skip-unchanged sequences.
module tb_calcore_instr_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [11:0] req_height;
    logic [11:0] req_weight;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd_h;
    logic [4:0]  req_rd_w;
    logic [4:0]  req_rd_bmi;
    logic [4:0]  req_rd_bmr;
    logic        instr_ready;

    logic        d0_req_ready;
    logic        d0_instr_valid;
    logic [31:0] d0_instr;
    logic        d0_busy;
    logic        d0_seq_done;

    logic        d1_req_ready;
    logic        d1_instr_valid;
    logic [31:0] d1_instr;
    logic        d1_busy;
    logic        d1_seq_done;

    int check_count = 0;
    int error_count = 0;

    localparam logic [31:0] W_A = 32'h0AF0008B;
    localparam logic [31:0] W_B = 32'h0460010C;
    localparam logic [31:0] W_C = 32'h0020818D;
    localparam logic [31:0] W_D = 32'h8220820E;

    typedef struct {
        logic        rst;
        logic        rv;
        logic        ir;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_rr;
    } vec_t;

    vec_t        vecs[30];
    logic [31:0] b2b_exp[8];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    calcore_instr_issuer #(.EMIT_BMR(1), .IDLE_GAP(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (d0_req_ready),
        .req_height  (req_height),
        .req_weight  (req_weight),
        .req_funct7  (req_funct7),
        .req_rd_h    (req_rd_h),
        .req_rd_w    (req_rd_w),
        .req_rd_bmi  (req_rd_bmi),
        .req_rd_bmr  (req_rd_bmr),
        .instr_valid (d0_instr_valid),
        .instr_ready (instr_ready),
        .instr       (d0_instr),
        .busy        (d0_busy),
        .seq_done    (d0_seq_done)
    );

    calcore_instr_issuer #(.EMIT_BMR(0), .IDLE_GAP(2)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (d1_req_ready),
        .req_height  (req_height),
        .req_weight  (req_weight),
        .req_funct7  (req_funct7),
        .req_rd_h    (req_rd_h),
        .req_rd_w    (req_rd_w),
        .req_rd_bmi  (req_rd_bmi),
        .req_rd_bmr  (req_rd_bmr),
        .instr_valid (d1_instr_valid),
        .instr_ready (instr_ready),
        .instr       (d1_instr),
        .busy        (d1_busy),
        .seq_done    (d1_seq_done)
    );

    function automatic vec_t mk(input logic r, input logic rv, input logic ir,
                                input logic v, input logic [31:0] w,
                                input logic b, input logic d, input logic rr);
        vec_t t;
        t.rst = r;  t.rv = rv; t.ir = ir;
        t.exp_valid = v; t.exp_instr = w; t.exp_busy = b; t.exp_done = d; t.exp_rr = rr;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        req_valid   = v.rv;
        instr_ready = v.ir;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setRequest(input logic [11:0] h, input logic [11:0] w, input logic [6:0] f7,
                              input logic [4:0] rh, input logic [4:0] rw,
                              input logic [4:0] rbmi, input logic [4:0] rbmr);
        req_height = h;
        req_weight = w;
        req_funct7 = f7;
        req_rd_h   = rh;
        req_rd_w   = rw;
        req_rd_bmi = rbmi;
        req_rd_bmr = rbmr;
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef CALCORE_SKIP_UNCHANGED_EN
    // Issue the current request on dut0 and collect its words until seq_done.
    task automatic collectSeq(input string name);
        logic done_seen;
        done_seen = 1'b0;
        words.delete();
        req_valid   = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (d0_seq_done) begin
                done_seen = 1'b1;
                break;
            end
            if (d0_instr_valid && instr_ready) words.push_back(d0_instr);
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_done"}, 32'(done_seen), 32'd1);
    endtask
`endif

    initial begin
        // Default configuration: basic sequence, stall in EMIT_W, reset in EMIT_BMI.
        vecs[0]  = mk(1, 0, 1, 0, 32'h0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 32'h0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 1, 1, W_A,   1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, W_B,   1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 1, W_C,   1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 1, W_D,   1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, W_D,   0, 1, 1);
        vecs[7]  = mk(1, 0, 1, 0, W_D,   0, 0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 32'h0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 1, 1, W_A,   1, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, W_B,   1, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, W_B,   1, 0, 0);
        vecs[12] = mk(0, 0, 0, 1, W_B,   1, 0, 0);
        vecs[13] = mk(0, 0, 1, 1, W_B,   1, 0, 0);
        vecs[14] = mk(0, 0, 1, 1, W_C,   1, 0, 0);
        vecs[15] = mk(0, 0, 1, 1, W_D,   1, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, W_D,   0, 1, 1);
        vecs[17] = mk(1, 0, 1, 0, W_D,   0, 0, 0);
        vecs[18] = mk(0, 1, 1, 0, 32'h0, 0, 0, 1);
        vecs[19] = mk(0, 0, 1, 1, W_A,   1, 0, 0);
        vecs[20] = mk(0, 0, 1, 1, W_B,   1, 0, 0);
        vecs[21] = mk(1, 0, 1, 1, W_C,   1, 0, 0);
        vecs[22] = mk(0, 0, 1, 0, 32'h0, 0, 0, 1);
        vecs[23] = mk(0, 1, 1, 0, 32'h0, 0, 0, 1);
        vecs[24] = mk(0, 0, 1, 1, W_A,   1, 0, 0);
        vecs[25] = mk(0, 0, 1, 1, W_B,   1, 0, 0);
        vecs[26] = mk(0, 0, 1, 1, W_C,   1, 0, 0);
        vecs[27] = mk(0, 0, 1, 1, W_D,   1, 0, 0);
        vecs[28] = mk(0, 0, 1, 0, W_D,   0, 1, 1);
        vecs[29] = mk(0, 0, 1, 0, W_D,   0, 0, 1);

        b2b_exp[0] = W_A;          b2b_exp[1] = W_B;
        b2b_exp[2] = W_C;          b2b_exp[3] = W_D;
        b2b_exp[4] = 32'h0B40028B; b2b_exp[5] = 32'h0500030C;
        b2b_exp[6] = 32'h0062838D; b2b_exp[7] = 32'h4062840E;

        rst         = 1'b1;
        req_valid   = 1'b0;
        instr_ready = 1'b1;
        setRequest(12'd175, 12'd70, 7'h41, 5'd1, 5'd2, 5'd3, 5'd4);
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_ctrl", i),
                        {28'h0, d0_instr_valid, d0_busy, d0_seq_done, d0_req_ready},
                        {28'h0, vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_rr});
            checkOutput($sformatf("vec%0d_instr", i), d0_instr, vecs[i].exp_instr);
            @(posedge clk);
            #1;
        end

        // Back-to-back: second request presented in the seq_done cycle; request
        // port scrambled while busy to show the latched copy is used.
        begin
            logic second_sent;
            second_sent = 1'b0;
            resetDut();
            instr_ready = 1'b1;
            setRequest(12'd175, 12'd70, 7'h41, 5'd1, 5'd2, 5'd3, 5'd4);
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            setRequest(12'hFFF, 12'h123, 7'h7F, 5'd31, 5'd30, 5'd29, 5'd28);
            words.delete();
            for (int c = 0; c < 20; c++) begin
                req_valid = 1'b0;
                if (d0_instr_valid && instr_ready) words.push_back(d0_instr);
                if (d0_seq_done && !second_sent) begin
                    checkOutput("b2b_req_ready", 32'(d0_req_ready), 32'd1);
                    setRequest(12'd180, 12'd80, 7'h20, 5'd5, 5'd6, 5'd7, 5'd8);
                    req_valid   = 1'b1;
                    second_sent = 1'b1;
                end
                @(posedge clk);
                #1;
                if (second_sent && req_valid) begin
                    checkOutput("b2b_accepted_busy", 32'(d0_busy), 32'd1);
                end
            end
            req_valid = 1'b0;
            checkOutput("b2b_word_count", 32'(words.size()), 32'd8);
            for (int i = 0; i < 8; i++) begin
                if (i < words.size()) checkOutput($sformatf("b2b_word%0d", i), words[i], b2b_exp[i]);
            end
        end

        // Idle gap of 2 with BMR disabled (dut1): per-cycle {valid, busy, done}.
        begin
            logic [2:0]  gap_ctrl[10];
            logic [31:0] gap_word[10];
            gap_ctrl[0] = 3'b110; gap_word[0] = W_A;
            gap_ctrl[1] = 3'b010; gap_word[1] = 32'h0;
            gap_ctrl[2] = 3'b010; gap_word[2] = 32'h0;
            gap_ctrl[3] = 3'b110; gap_word[3] = W_B;
            gap_ctrl[4] = 3'b010; gap_word[4] = 32'h0;
            gap_ctrl[5] = 3'b010; gap_word[5] = 32'h0;
            gap_ctrl[6] = 3'b110; gap_word[6] = W_C;
            gap_ctrl[7] = 3'b001; gap_word[7] = 32'h0;
            gap_ctrl[8] = 3'b000; gap_word[8] = 32'h0;
            gap_ctrl[9] = 3'b000; gap_word[9] = 32'h0;
            resetDut();
            instr_ready = 1'b1;
            setRequest(12'd175, 12'd70, 7'h41, 5'd1, 5'd2, 5'd3, 5'd4);
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                checkOutput($sformatf("gap_cyc%0d_ctrl", k + 1),
                            {29'h0, d1_instr_valid, d1_busy, d1_seq_done},
                            {29'h0, gap_ctrl[k]});
                if (gap_ctrl[k][2]) checkOutput($sformatf("gap_cyc%0d_instr", k + 1), d1_instr, gap_word[k]);
                @(posedge clk);
                #1;
            end
        end

`ifdef CALCORE_SKIP_UNCHANGED_EN
        // Skip-unchanged: identical repeat issues only BMI/BMR; new weight re-issues W.
        resetDut();
        setRequest(12'd175, 12'd70, 7'h41, 5'd1, 5'd2, 5'd3, 5'd4);
        collectSeq("skip_first");
        checkOutput("skip_first_count", 32'(words.size()), 32'd4);
        collectSeq("skip_repeat");
        checkOutput("skip_repeat_count", 32'(words.size()), 32'd2);
        if (words.size() == 2) begin
            checkOutput("skip_repeat_w0", words[0], W_C);
            checkOutput("skip_repeat_w1", words[1], W_D);
        end
        setRequest(12'd175, 12'd71, 7'h41, 5'd1, 5'd2, 5'd3, 5'd4);
        collectSeq("skip_weight");
        checkOutput("skip_weight_count", 32'(words.size()), 32'd3);
        if (words.size() == 3) begin
            checkOutput("skip_weight_w0", words[0], 32'h0470010C);
            checkOutput("skip_weight_w1", words[1], W_C);
            checkOutput("skip_weight_w2", words[2], W_D);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/calcore_instr_issuer.md
Name: calcore_instr_issuer

Overview:
- Instruction-side counterpart of the CalCore decoder: takes one host "profile" request (height, weight, BMR mode, target registers) and encodes and issues the fixed CalCore instruction sequence, one word per valid/ready handshake.
- Sequence: SET_HEIGHT, SET_WEIGHT, CALC_BMI, CALC_BMR.
- Sits between the host/testbench command port and the core's instruction fetch input.

Parameters:
- EMIT_BMR, 1: 1 = sequence ends with CALC_BMR; 0 = sequence ends after CALC_BMI.
- IDLE_GAP, 0: number of idle cycles (instr_valid low) inserted after each completed instruction handshake, range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_height  in  12  unsigned height immediate.
- req_weight  in  12  unsigned weight immediate.
- req_funct7  in  7  BMR mode field.
- req_rd_h  in  5  register receiving height.
- req_rd_w  in  5  register receiving weight.
- req_rd_bmi  in  5  BMI destination.
- req_rd_bmr  in  5  BMR destination.
- instr_valid  out  1  instruction word valid.
- instr_ready  in  1  consumer accepts word.
- instr  out  32  encoded instruction.
- busy  out  1  high whenever state != IDLE.
- seq_done  out  1  one-cycle pulse after the last handshake of a sequence.

Behaviour:
- Encoding, per ISA field map:
  - opcode = instr[6:0]; rd = [11:7]; funct3 = [14:12] = 000; rs1 = [19:15]; rs2 = [24:20]; funct7 = [31:25]; imm = [31:20].
  - SET_HEIGHT (7'b0001011): I-type, imm = height, rs1 = 0, rd = rd_h.
  - SET_WEIGHT (7'b0001100): I-type, imm = weight, rs1 = 0, rd = rd_w.
  - CALC_BMI (7'b0001101): R-type, rs1 = rd_h, rs2 = rd_w, funct7 = 0, rd = rd_bmi.
  - CALC_BMR (7'b0001110): R-type, rs1 = rd_h, rs2 = rd_w, funct7 = req_funct7, rd = rd_bmr.
- FSM states: IDLE, EMIT_H, EMIT_W, EMIT_BMI, EMIT_BMR, GAP.
- IDLE:
  - req_ready = 1. On req_valid & req_ready, all request fields are latched and the next state is EMIT_H.
  - instr_valid rises the cycle after acceptance (latency 1).
- EMIT_x:
  - instr is driven from a register, instr_valid = 1.
  - instr and instr_valid are held stable while instr_valid & !instr_ready.
  - On handshake, the next state is the next emit state, or GAP if IDLE_GAP > 0. GAP remembers the pending next state.
- GAP: a 4-bit counter runs IDLE_GAP cycles with instr_valid = 0, then enters the pending state.
- Sequence end:
  - The final handshake (EMIT_BMR, or EMIT_BMI if EMIT_BMR = 0) leads to IDLE and pulses seq_done for one cycle.
  - The gap is not applied after the final instruction.
  - req_ready is high in the same cycle as the seq_done pulse, so back-to-back requests are accepted.
- Request fields change while busy: ignored; the latched copy is used.
- instr_ready while instr_valid = 0: ignored.
- Reset values: req_ready = 0 during rst, then 1; instr_valid = 0; instr = 0; busy = 0; seq_done = 0; GAP counter = 0.
- Reset mid-sequence: the sequence is aborted with no further words; the state returns to IDLE the next cycle.
- rd = 0: encoded as-is; no checking.

Optional Feature:
- Macro CALCORE_SKIP_UNCHANGED_EN.
- Defined:
  - The block keeps the last issued {height, rd_h} and {weight, rd_w} with valid flags, which reset clears.
  - EMIT_H and EMIT_W are skipped (zero cycles, no gap) when the latched value and register match a valid cached entry.
  - CALC_BMI and CALC_BMR are always issued.
  - A cache entry updates only on that instruction's handshake.
- Undefined: no cache; every sequence issues all instructions.

Decomposition:
- Package calcore_pkg holds:
  - opcode constants OP_SET_HEIGHT, OP_SET_WEIGHT, OP_CALC_BMI, OP_CALC_BMR;
  - field width constants REG_W = 5, IMM_W = 12, F7_W = 7;
  - state enum issuer_state_t.
- One natural sub-module: calcore_instr_encode, a combinational (op, rd, rs1, rs2, imm, funct7) -> 32-bit word encoder, reusable by the testbench reference model.

Test Plan:
- Request height = 175, weight = 70, rd_h = 1, rd_w = 2, rd_bmi = 3, rd_bmr = 4, funct7 = 0x41, instr_ready = 1, IDLE_GAP = 0:
  - expect words 0x0AF0008B, 0x0460010C, 0x0020818D, 0x8220820E on 4 consecutive cycles starting 1 cycle after acceptance;
  - expect a seq_done pulse the cycle after the last word.
- Same request with instr_ready low for 3 cycles during EMIT_W: 0x0460010C is held stable with instr_valid = 1; no word is lost or duplicated.
- IDLE_GAP = 2, EMIT_BMR = 0: 3 words, each followed by 2 cycles of instr_valid = 0 except the last; seq_done follows 0x0020818D.
- Assert rst while in EMIT_BMI: the next cycle has instr_valid = 0, busy = 0, req_ready = 1; a new request restarts from SET_HEIGHT.
- Two back-to-back requests, the second presented in the seq_done cycle: it is accepted immediately; exactly 8 words, in order.
- With CALCORE_SKIP_UNCHANGED_EN, repeat an identical request: only 0x0020818D and 0x8220820E are issued. With weight changed to 71: 0x0470010C, BMI, BMR.
